if_fetch_unit: RTL and testbench
================================

// Module: if_fetch_unit
// PURPOSE
// Instruction-fetch stage directly upstream of the IF/ID pipeline register. Owns the PC,
// issues reads to instruction memory over a busywait handshake, and holds a fetched word
// while the pipeline is stalled. Applies branch/jump redirects, including one that arrives
// mid-access. Drives PC_OUT, PC_PLUS_FOUR_OUT and INSTRUCTION_OUT into IF/ID, plus BUSYWAIT,
// which IF/ID uses as its hold signal.
// PARAMETERS
// RESET_PC   32'h0000_0000  PC value loaded on reset
// NOP_INSTR  32'h0000_0013  word driven on INSTRUCTION_OUT when no valid instruction (addi x0,x0,0)
// PORTS
// CLK             in   1   clock, rising edge
// RESET           in   1   asynchronous, active-low reset
// STALL           in   1   hazard unit: hold current instruction, do not advance PC
// BRANCH_TAKEN    in   1   redirect request, one-cycle pulse
// BRANCH_TARGET   in   32  redirect address; bits [1:0] forced to 0 internally
// IMEM_READDATA   in   32  instruction word, valid when IMEM_READ=1 and IMEM_BUSYWAIT=0
// IMEM_BUSYWAIT   in   1   memory busy; access completes in the first cycle it is 0
// IMEM_READ       out  1   read request
// IMEM_ADDRESS    out  32  read address (=PC, or the old PC while discarding)
// PC_OUT          out  32  PC of INSTRUCTION_OUT
// PC_PLUS_FOUR_OUT out 32  PC_OUT+4, modulo 2^32
// INSTRUCTION_OUT out  32  fetched instruction
// BUSYWAIT        out  1   1 = IF/ID must hold (no valid instruction, or STALL)
// BEHAVIOUR
// - Reset (RESET=0, async): PC=RESET_PC, state=FETCH, hold buffer=NOP_INSTR, pending target=0.
//   While RESET=0: IMEM_READ=0, IMEM_ADDRESS=RESET_PC, PC_OUT=RESET_PC,
//   PC_PLUS_FOUR_OUT=RESET_PC+4, INSTRUCTION_OUT=NOP_INSTR, BUSYWAIT=1.
// - States: FETCH (read in flight on PC), HOLD (word buffered, waiting for STALL=0),
//   DISCARD (redirect arrived mid-access; finish the old access, drop it, refetch).
// - IMEM_READ=1 in FETCH and DISCARD only. IMEM_ADDRESS stays stable until the access
//   completes; it is never changed while IMEM_BUSYWAIT=1.
// - valid = (FETCH & ~IMEM_BUSYWAIT) | HOLD. INSTRUCTION_OUT = IMEM_READDATA in FETCH, the
//   hold buffer in HOLD, and NOP_INSTR otherwise. BUSYWAIT = ~valid | STALL | BRANCH_TAKEN.
// - FETCH, no redirect: if IMEM_BUSYWAIT=1, stay. On completion with STALL=0: PC<=PC+4 and
//   stay in FETCH, so IF/ID captures on the same edge; best case is 1 instruction/cycle.
//   On completion with STALL=1: buffer <= IMEM_READDATA, go to HOLD.
// - HOLD: when STALL=0, PC<=PC+4 and go to FETCH (IF/ID captures the buffer on that edge).
// - Redirect (BRANCH_TAKEN=1) has priority over STALL and over completion:
//   FETCH & IMEM_BUSYWAIT=1 -> pending<=target, go to DISCARD.
//   FETCH & completing -> drop data, PC<=target, stay in FETCH.
//   HOLD -> drop buffer, PC<=target, go to FETCH.
//   DISCARD -> pending<=target (latest redirect wins).
// - DISCARD: BUSYWAIT=1. When IMEM_BUSYWAIT=0, drop data, PC<=pending, go to FETCH
//   (or PC<=BRANCH_TARGET if a redirect arrives in that same cycle).
// - Flushing the wrong-path instruction already in IF/ID is the hazard unit's job, not this block's.
// - PC arithmetic is 32-bit and wraps: PC 32'hFFFF_FFFC advances to 32'h0000_0000.
// - RESET assertion in any state aborts immediately; IMEM_READ drops asynchronously.
// TESTING
// 1 Zero-wait memory, STALL=0, reset released -> IMEM_ADDRESS 0,4,8,C on consecutive
//   cycles; BUSYWAIT=0 every cycle; PC_PLUS_FOUR_OUT=PC_OUT+4.
// 2 IMEM_BUSYWAIT=1 for 3 cycles on addr 0x10 -> address stable for 4 cycles; BUSYWAIT=1
//   for 3 cycles; word at 0x10 presented with BUSYWAIT=0 in the 4th cycle.
// 3 STALL=1 for 2 cycles at completion of 0x20 -> HOLD; INSTRUCTION_OUT holds the 0x20 word
//   and BUSYWAIT=1; IMEM_READ=0; after STALL=0, next IMEM_ADDRESS is 0x24.
// 4 BRANCH_TAKEN, target 0x100, while 0x30 is busy -> IMEM_ADDRESS stays 0x30 until done;
//   0x30 word never has BUSYWAIT=0; next access is 0x100.
// 5 Two redirects in DISCARD (0x200 then 0x300) -> next access is 0x300. Target 0x102 -> 0x100.
// 6 RESET_PC=32'hFFFF_FFFC -> second fetch address is 0x0. RESET=0 mid-wait -> IMEM_READ=0
//   immediately; the restart fetches from RESET_PC.

Source files
------------

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage feeding the IF/ID register: owns the PC, runs the
// busywait read handshake to instruction memory, buffers a word across stalls.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        STALL,
  input  logic        BRANCH_TAKEN,
  input  logic [31:0] BRANCH_TARGET,
  input  logic [31:0] IMEM_READDATA,
  input  logic        IMEM_BUSYWAIT,
  output logic        IMEM_READ,
  output logic [31:0] IMEM_ADDRESS,
  output logic [31:0] PC_OUT,
  output logic [31:0] PC_PLUS_FOUR_OUT,
  output logic [31:0] INSTRUCTION_OUT,
  output logic        BUSYWAIT,
  output logic [1:0]  DEBUG_STATE
);

  // Handshake: a read is requested while IMEM_READ=1 and completes in the
  // first cycle IMEM_BUSYWAIT=0; IMEM_ADDRESS is frozen until then. Towards
  // IF/ID, an instruction is taken on the rising edge where BUSYWAIT=0.

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] hold_buf;
  logic [31:0] pending_pc;

  logic [31:0] branch_pc;
  logic [31:0] pc_plus_four;
  logic        in_fetch;
  logic        in_hold;
  logic        in_discard;
  logic        valid;
  logic        unused_target_lsbs;

  assign branch_pc          = {BRANCH_TARGET[31:2], 2'b00};
  assign pc_plus_four       = pc + 32'd4;
  assign unused_target_lsbs = ^BRANCH_TARGET[1:0];

  // Gating with RESET makes the outputs fall back to their idle values the
  // instant reset is asserted, not at the next clock edge.
  assign in_fetch   = RESET && (state == FETCH);
  assign in_hold    = RESET && (state == HOLD);
  assign in_discard = RESET && (state == DISCARD);

  assign valid            = (in_fetch && !IMEM_BUSYWAIT) || in_hold;
  assign IMEM_READ        = in_fetch || in_discard;
  assign IMEM_ADDRESS     = pc;
  assign PC_OUT           = pc;
  assign PC_PLUS_FOUR_OUT = pc_plus_four;
  assign BUSYWAIT         = !valid || STALL || BRANCH_TAKEN;
  assign DEBUG_STATE      = state;

  always_comb begin
    INSTRUCTION_OUT = NOP_INSTR;
    if (in_fetch)
      INSTRUCTION_OUT = IMEM_READDATA;
    else if (in_hold)
      INSTRUCTION_OUT = hold_buf;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      hold_buf   <= NOP_INSTR;
      pending_pc <= 32'h0000_0000;
    end else begin
      unique case (state)
        FETCH: begin
          if (BRANCH_TAKEN) begin
            // A redirect during a busy access cannot move the address yet,
            // so park the target and let the old access drain.
            if (IMEM_BUSYWAIT) begin
              pending_pc <= branch_pc;
              state      <= DISCARD;
            end else begin
              pc <= branch_pc;
            end
          end else if (!IMEM_BUSYWAIT) begin
            if (STALL) begin
              hold_buf <= IMEM_READDATA;
              state    <= HOLD;
            end else begin
              pc <= pc_plus_four;
            end
          end
        end

        HOLD: begin
          if (BRANCH_TAKEN) begin
            pc    <= branch_pc;
            state <= FETCH;
          end else if (!STALL) begin
            pc    <= pc_plus_four;
            state <= FETCH;
          end
        end

        DISCARD: begin
          if (!IMEM_BUSYWAIT) begin
            pc    <= BRANCH_TAKEN ? branch_pc : pending_pc;
            state <= FETCH;
          end else if (BRANCH_TAKEN) begin
            pending_pc <= branch_pc;
          end
        end

        default: begin
          state <= FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed handshake/stall/redirect/reset steps, then
// random traffic checked against an instruction-stream reference model.
module tb_if_fetch_unit;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        STALL = 1'b0;
  logic        BRANCH_TAKEN = 1'b0;
  logic [31:0] BRANCH_TARGET = 32'h0;
  logic        IMEM_BUSYWAIT = 1'b0;
  logic [31:0] IMEM_READDATA;
  logic        IMEM_READ;
  logic [31:0] IMEM_ADDRESS;
  logic [31:0] PC_OUT;
  logic [31:0] PC_PLUS_FOUR_OUT;
  logic [31:0] INSTRUCTION_OUT;
  logic        BUSYWAIT;
  logic [1:0]  DEBUG_STATE;

  // Second instance starting just below the wrap point; shares all inputs.
  logic [31:0] hi_readdata;
  logic        hi_read;
  logic [31:0] hi_address;
  logic [31:0] hi_pc;
  logic [31:0] hi_pc_plus_four;
  logic [31:0] hi_instruction;
  logic        hi_busywait;
  logic [1:0]  hi_state;

  localparam logic [31:0] NOP = 32'h0000_0013;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  assign IMEM_READDATA = mem_word(IMEM_ADDRESS);
  assign hi_readdata   = mem_word(hi_address);

  if_fetch_unit dut (
    .CLK(CLK), .RESET(RESET), .STALL(STALL), .BRANCH_TAKEN(BRANCH_TAKEN),
    .BRANCH_TARGET(BRANCH_TARGET), .IMEM_READDATA(IMEM_READDATA),
    .IMEM_BUSYWAIT(IMEM_BUSYWAIT), .IMEM_READ(IMEM_READ),
    .IMEM_ADDRESS(IMEM_ADDRESS), .PC_OUT(PC_OUT),
    .PC_PLUS_FOUR_OUT(PC_PLUS_FOUR_OUT), .INSTRUCTION_OUT(INSTRUCTION_OUT),
    .BUSYWAIT(BUSYWAIT), .DEBUG_STATE(DEBUG_STATE)
  );

  if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_hi (
    .CLK(CLK), .RESET(RESET), .STALL(STALL), .BRANCH_TAKEN(BRANCH_TAKEN),
    .BRANCH_TARGET(BRANCH_TARGET), .IMEM_READDATA(hi_readdata),
    .IMEM_BUSYWAIT(IMEM_BUSYWAIT), .IMEM_READ(hi_read),
    .IMEM_ADDRESS(hi_address), .PC_OUT(hi_pc),
    .PC_PLUS_FOUR_OUT(hi_pc_plus_four), .INSTRUCTION_OUT(hi_instruction),
    .BUSYWAIT(hi_busywait), .DEBUG_STATE(hi_state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  // Sample at the falling edge, then check a plain sequential fetch.
  task automatic seq_fetch(input logic [31:0] addr);
    @(negedge CLK);
    chk("seq_addr", IMEM_ADDRESS, addr);
    chk1("seq_busywait", BUSYWAIT, 1'b0);
    chk("seq_instr", INSTRUCTION_OUT, mem_word(addr));
    next_cycle();
  endtask

  // Reference model state for the random phase
  logic [31:0] next_pc;
  logic        prev_pending;
  logic [31:0] prev_addr;
  int          accepted;
  logic [31:0] tgt;

  initial begin
    // Reset values
    #12;
    chk1("rst_read", IMEM_READ, 1'b0);
    chk("rst_addr", IMEM_ADDRESS, 32'h0);
    chk("rst_pc", PC_OUT, 32'h0);
    chk("rst_pc4", PC_PLUS_FOUR_OUT, 32'h4);
    chk("rst_instr", INSTRUCTION_OUT, NOP);
    chk1("rst_busywait", BUSYWAIT, 1'b1);
    chk("rst_hi_addr", hi_address, 32'hFFFF_FFFC);
    next_cycle();
    RESET = 1'b1;

    // Zero-wait streaming; the high instance wraps to 0
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      chk("t1_addr", IMEM_ADDRESS, 32'(i * 4));
      chk1("t1_busywait", BUSYWAIT, 1'b0);
      chk("t1_pc4", PC_PLUS_FOUR_OUT, PC_OUT + 32'd4);
      chk("t1_instr", INSTRUCTION_OUT, mem_word(32'(i * 4)));
      if (i == 0) begin
        chk("t6_hi_first", hi_address, 32'hFFFF_FFFC);
        chk("t6_hi_pc4_wrap", hi_pc_plus_four, 32'h0);
      end
      if (i == 1) chk("t6_hi_second", hi_address, 32'h0);
      next_cycle();
    end

    // Three wait cycles on 0x10
    IMEM_BUSYWAIT = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("t2_addr_stable", IMEM_ADDRESS, 32'h10);
      chk1("t2_read", IMEM_READ, 1'b1);
      chk1("t2_busywait", BUSYWAIT, 1'b1);
      next_cycle();
    end
    IMEM_BUSYWAIT = 1'b0;
    seq_fetch(32'h10);
    for (int a = 32'h14; a <= 32'h1C; a += 4) seq_fetch(32'(a));

    // Stall across the completion of 0x20
    STALL = 1'b1;
    @(negedge CLK);
    chk("t3_addr", IMEM_ADDRESS, 32'h20);
    chk1("t3_busywait_c", BUSYWAIT, 1'b1);
    chk("t3_instr_c", INSTRUCTION_OUT, mem_word(32'h20));
    next_cycle();
    @(negedge CLK);
    chk1("t3_read_hold", IMEM_READ, 1'b0);
    chk("t3_instr_hold", INSTRUCTION_OUT, mem_word(32'h20));
    chk1("t3_busywait_hold", BUSYWAIT, 1'b1);
    next_cycle();
    STALL = 1'b0;
    @(negedge CLK);
    chk1("t3_release_bw", BUSYWAIT, 1'b0);
    chk("t3_release_instr", INSTRUCTION_OUT, mem_word(32'h20));
    chk("t3_release_pc", PC_OUT, 32'h20);
    next_cycle();
    seq_fetch(32'h24);
    seq_fetch(32'h28);
    seq_fetch(32'h2C);

    // Redirect to 0x100 while 0x30 is busy
    IMEM_BUSYWAIT = 1'b1;
    BRANCH_TAKEN = 1'b1;
    BRANCH_TARGET = 32'h100;
    @(negedge CLK);
    chk("t4_addr0", IMEM_ADDRESS, 32'h30);
    chk1("t4_bw0", BUSYWAIT, 1'b1);
    next_cycle();
    BRANCH_TAKEN = 1'b0;
    @(negedge CLK);
    chk("t4_addr1", IMEM_ADDRESS, 32'h30);
    chk1("t4_read1", IMEM_READ, 1'b1);
    chk1("t4_bw1", BUSYWAIT, 1'b1);
    next_cycle();
    IMEM_BUSYWAIT = 1'b0;
    @(negedge CLK);
    chk("t4_addr_done", IMEM_ADDRESS, 32'h30);
    chk1("t4_dropped", BUSYWAIT, 1'b1);
    next_cycle();
    seq_fetch(32'h100);

    // Two redirects while discarding; latest wins
    IMEM_BUSYWAIT = 1'b1;
    BRANCH_TAKEN = 1'b1;
    BRANCH_TARGET = 32'h200;
    @(negedge CLK);
    chk("t5_addr0", IMEM_ADDRESS, 32'h104);
    next_cycle();
    BRANCH_TARGET = 32'h300;
    @(negedge CLK);
    chk("t5_addr1", IMEM_ADDRESS, 32'h104);
    chk1("t5_bw1", BUSYWAIT, 1'b1);
    next_cycle();
    BRANCH_TAKEN = 1'b0;
    IMEM_BUSYWAIT = 1'b0;
    @(negedge CLK);
    chk("t5_addr2", IMEM_ADDRESS, 32'h104);
    chk1("t5_bw2", BUSYWAIT, 1'b1);
    next_cycle();
    seq_fetch(32'h300);
    // Misaligned target is rounded down
    BRANCH_TAKEN = 1'b1;
    BRANCH_TARGET = 32'h102;
    @(negedge CLK);
    chk("t5_addr_304", IMEM_ADDRESS, 32'h304);
    chk1("t5_bw_304", BUSYWAIT, 1'b1);
    next_cycle();
    BRANCH_TAKEN = 1'b0;
    @(negedge CLK);
    chk("t5_aligned", IMEM_ADDRESS, 32'h100);
    chk("t5_aligned_pc", PC_OUT, 32'h100);
    chk1("t5_aligned_bw", BUSYWAIT, 1'b0);
    next_cycle();

    // Reset asserted mid-wait
    IMEM_BUSYWAIT = 1'b1;
    #2;
    chk1("t6_read_before", IMEM_READ, 1'b1);
    chk("t6_addr_before", IMEM_ADDRESS, 32'h104);
    #1;
    RESET = 1'b0;
    #1;
    chk1("t6_read_async", IMEM_READ, 1'b0);
    chk("t6_addr_async", IMEM_ADDRESS, 32'h0);
    chk("t6_instr_async", INSTRUCTION_OUT, NOP);
    chk1("t6_bw_async", BUSYWAIT, 1'b1);
    next_cycle();
    RESET = 1'b1;
    IMEM_BUSYWAIT = 1'b0;
    @(negedge CLK);
    chk1("t6_restart_read", IMEM_READ, 1'b1);
    chk("t6_restart_addr", IMEM_ADDRESS, 32'h0);
    chk1("t6_restart_bw", BUSYWAIT, 1'b0);
    next_cycle();

    // Random traffic against the instruction-stream model: each accepted
    // instruction must be the next one of the architectural path.
    RESET = 1'b0;
    #3;
    RESET = 1'b1;
    next_pc = 32'h0;
    prev_pending = 1'b0;
    prev_addr = 32'h0;
    accepted = 0;
    for (int c = 0; c < 3000; c++) begin
      IMEM_BUSYWAIT = ($urandom_range(0, 2) == 0);
      STALL = ($urandom_range(0, 3) == 0);
      BRANCH_TAKEN = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 3) == 0) tgt = {28'hFFF_FFFF, 4'($urandom_range(0, 15))};
      else tgt = $urandom;
      BRANCH_TARGET = tgt;
      @(negedge CLK);
      if (prev_pending) begin
        chk1("rnd_read_held", IMEM_READ, 1'b1);
        chk("rnd_addr_held", IMEM_ADDRESS, prev_addr);
      end
      if (STALL || BRANCH_TAKEN) chk1("rnd_forced_bw", BUSYWAIT, 1'b1);
      if (BUSYWAIT === 1'b0) begin
        chk("rnd_pc", PC_OUT, next_pc);
        chk("rnd_pc4", PC_PLUS_FOUR_OUT, next_pc + 32'd4);
        chk("rnd_instr", INSTRUCTION_OUT, mem_word(next_pc));
        next_pc = next_pc + 32'd4;
        accepted++;
      end
      if (BRANCH_TAKEN) next_pc = {tgt[31:2], 2'b00};
      prev_pending = IMEM_READ && IMEM_BUSYWAIT;
      prev_addr = IMEM_ADDRESS;
      next_cycle();
    end
    STALL = 1'b0;
    BRANCH_TAKEN = 1'b0;
    IMEM_BUSYWAIT = 1'b0;
    chk1("rnd_progress", accepted > 300, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
